xbus_arbiter: RTL
=================

Name: xbus_arbiter

Overview:
- Sequences the multiplexed external bus of the 51 core: P0 carries low address and data, P2 carries high address; drives ALE, PSEN, RD and WR.
- Shares the bus between two requesters: program-code fetch (PC side) and MOVX data access (XDATA side).
- Each transfer runs a fixed address/latch/strobe/end sequence; a one-cycle ack and read data are returned to the granted requester.

Parameters:
- WAIT_CYCLES, 1, extra clocks the strobe is held low beyond the first (legal 0..7).
- ADDR_W, 16, external address width; P2 carries ADDR_W-8 bits.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous reset, active-low
- code_req  input  1  code fetch request, level
- code_addr  input  16  code address, stable while code_req is high
- code_ack  output  1  one-cycle pulse, code transfer complete
- code_rdata  output  8  fetched byte
- data_req  input  1  MOVX request, level
- data_we  input  1  1 = MOVX write, 0 = MOVX read
- data_addr  input  16  XDATA address (DPTR, or P2:Ri)
- data_wdata  input  8  write byte
- data_ack  output  1  one-cycle pulse, data transfer complete
- data_rdata  output  8  read byte
- ALE  output  1  address latch enable, active-high
- PSEN  output  1  program strobe, active-low
- RD  output  1  data read strobe, active-low
- WR  output  1  data write strobe, active-low
- p0_out  output  8  P0 drive value
- p0_oe  output  1  P0 output enable
- p0_in  input  8  P0 pin value
- p2_out  output  8  P2 drive value (high address)
- busy  output  1  1 when the FSM is not in IDLE

Behaviour:
- Reset (async, reset=0): takes effect immediately, including mid-transfer, with no completion ack.
  - FSM=IDLE, ALE=0, PSEN=RD=WR=1, p0_oe=0, p0_out=8'h00, p2_out=8'hFF.
  - code_ack=data_ack=0, code_rdata=data_rdata=8'h00, busy=0.
  - last_grant=DATA, so code wins the first contention after reset.
- FSM states: IDLE, ADDR, LATCH, STROBE, END.
- IDLE: strobes inactive, p0_oe=0, p2_out holds last value.
  - If any req is high at the edge, latch the granted requester's addr, we and wdata, then go to ADDR.
  - Code requests are always reads.
- Arbitration:
  - Only one req high: grant it.
  - Both high: grant the requester that is not last_grant, then update last_grant (alternation, no starvation).
  - The loser keeps req high and waits.
- ADDR (1 clk): ALE=1, p0_out=addr[7:0], p0_oe=1, p2_out=addr[15:8].
- LATCH (1 clk): ALE=0; P0 and P2 keep the address (hold time).
- STROBE (1+WAIT_CYCLES clks): 3-bit counter.
  - Code: PSEN=0. Data read: RD=0. Data write: WR=0.
  - Read: p0_oe=0. Write: p0_out=wdata, p0_oe=1.
  - On the edge ending the last STROBE clock, a read captures p0_in into code_rdata or data_rdata.
- END (1 clk): all strobes=1 and the granted ack=1.
  - Write: p0_out=wdata, p0_oe=1 (data hold); read: p0_oe=0.
  - Next state is always IDLE.
- Rdata stays valid from the ack cycle until that requester's next read capture.
- Requesters drop req in their ack cycle.
  - req is only sampled in IDLE, so the ack cycle never re-grants.
  - A req still high in the following IDLE starts a new transfer.
- Address and wdata are registered at grant; input changes after grant do not affect the transfer.
- Dropping req after grant does not abort the transfer; it completes and acks.
- Latency with WAIT_CYCLES=W: req sampled in IDLE at cycle n gives ADDR n+1, LATCH n+2, STROBE n+3..n+3+W, ack at n+4+W, IDLE at n+5+W.
- Never more than one strobe low; ALE and strobes never active together.
- busy = (state != IDLE).

Test Plan:
- Reset release, code_req=1, code_addr=16'h1234, p0_in=8'hA5, W=1:
  - ALE=1 and p0_out=34, p2_out=12 at n+1; PSEN=0 at n+3..n+4.
  - code_ack at n+5, code_rdata=8'hA5, RD=WR=1 throughout.
- data_req=1, data_we=1, data_addr=16'h00F0, data_wdata=8'h5C:
  - WR=0 for 2 clks with p0_out=5C, p0_oe=1, also through END.
  - data_ack one pulse, PSEN/RD stay 1.
- code_req and data_req both held high for 4 transfers after reset:
  - Grant order code, data, code, data; each ack is 1 clk; 6 clks per transfer.
- WAIT_CYCLES=0 and WAIT_CYCLES=7, data read:
  - RD low exactly 1 and 8 clks; data_rdata captures p0_in from the last low clock.
- Reset asserted during STROBE of a data write:
  - WR=1, p0_oe=0, p2_out=FF immediately; no data_ack.
  - After release, a pending data_req restarts from ADDR.
- data_addr changed during LATCH; data_req dropped during STROBE:
  - P0/P2 keep the original address; the transfer completes with data_ack; no second transfer.

Source files
------------

// File: rtl/xbus_arbiter.sv
// External bus sequencer for the 51 core: multiplexed P0 address/data, P2 high address,
// ALE/PSEN/RD/WR strobes, shared between code fetch and MOVX data requesters.
module xbus_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        code_req,
    input  logic [15:0] code_addr,
    output logic        code_ack,
    output logic [7:0]  code_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [15:0] data_addr,
    input  logic [7:0]  data_wdata,
    output logic        data_ack,
    output logic [7:0]  data_rdata,
    output logic        ALE,
    output logic        PSEN,
    output logic        RD,
    output logic        WR,
    output logic [7:0]  p0_out,
    output logic        p0_oe,
    input  logic [7:0]  p0_in,
    output logic [7:0]  p2_out,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_LATCH  = 3'd2,
        S_STROBE = 3'd3,
        S_END    = 3'd4
    } state_t;

    state_t      state_q;
    logic        last_data_q;
    logic        is_data_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [2:0]  cnt_q;
    logic        ale_q, psen_q, rd_q, wr_q;
    logic [7:0]  p0_out_q, p2_out_q;
    logic        p0_oe_q;
    logic        code_ack_q, data_ack_q;
    logic [7:0]  code_rdata_q, data_rdata_q;
    logic        busy_q;

    // Data wins only when code is idle or code was served last, so contention alternates.
    logic              gnt_data;
    logic [ADDR_W-1:0] gnt_addr;
    assign gnt_data = data_req & (~code_req | ~last_data_q);
    assign gnt_addr = gnt_data ? data_addr[ADDR_W-1:0] : code_addr[ADDR_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_data_q  <= 1'b1;
            is_data_q    <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= 8'h00;
            cnt_q        <= 3'd0;
            ale_q        <= 1'b0;
            psen_q       <= 1'b1;
            rd_q         <= 1'b1;
            wr_q         <= 1'b1;
            p0_out_q     <= 8'h00;
            p0_oe_q      <= 1'b0;
            p2_out_q     <= 8'hFF;
            code_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
            code_rdata_q <= 8'h00;
            data_rdata_q <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            code_ack_q <= 1'b0;
            data_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (code_req || data_req) begin
                        // The P0/P2 output registers double as the latched transfer address.
                        state_q     <= S_ADDR;
                        is_data_q   <= gnt_data;
                        last_data_q <= gnt_data;
                        we_q        <= gnt_data & data_we;
                        wdata_q     <= data_wdata;
                        ale_q       <= 1'b1;
                        p0_out_q    <= gnt_addr[7:0];
                        p0_oe_q     <= 1'b1;
                        p2_out_q    <= 8'(gnt_addr >> 8);
                        busy_q      <= 1'b1;
                    end
                end
                S_ADDR: begin
                    state_q <= S_LATCH;
                    ale_q   <= 1'b0;
                end
                S_LATCH: begin
                    state_q <= S_STROBE;
                    cnt_q   <= 3'd0;
                    psen_q  <= is_data_q;
                    rd_q    <= ~(is_data_q & ~we_q);
                    wr_q    <= ~(is_data_q & we_q);
                    p0_oe_q <= we_q;
                    if (we_q) begin
                        p0_out_q <= wdata_q;
                    end
                end
                S_STROBE: begin
                    if (cnt_q == 3'(WAIT_CYCLES)) begin
                        state_q    <= S_END;
                        psen_q     <= 1'b1;
                        rd_q       <= 1'b1;
                        wr_q       <= 1'b1;
                        code_ack_q <= ~is_data_q;
                        data_ack_q <= is_data_q;
                        if (!we_q) begin
                            if (is_data_q) begin
                                data_rdata_q <= p0_in;
                            end else begin
                                code_rdata_q <= p0_in;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_END: begin
                    state_q <= S_IDLE;
                    p0_oe_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ALE        = ale_q;
    assign PSEN       = psen_q;
    assign RD         = rd_q;
    assign WR         = wr_q;
    assign p0_out     = p0_out_q;
    assign p0_oe      = p0_oe_q;
    assign p2_out     = p2_out_q;
    assign code_ack   = code_ack_q;
    assign data_ack   = data_ack_q;
    assign code_rdata = code_rdata_q;
    assign data_rdata = data_rdata_q;
    assign busy       = busy_q;

endmodule
